wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back stage and 16x16 register file; consumes the MEM/WB pipeline register outputs.
//  Selects the write-back value (memory read data or ALU result) and commits it to the array.
//  Also commits the R15 side result (mul/div) and swap writes.
//  Serves two ID-stage read ports and one R15 read port, with same-cycle write-through bypass.
// PARAMETERS
//  DW     16  data width of registers and all data ports
//  AW     4   register address width (2**AW registers)
//  R15IDX 15  index of the dedicated side-result register
// PORTS
//  clk        in   1   clock; all writes on rising edge
//  rst        in   1   asynchronous, active-high reset
//  RegWrt     in   1   primary write enable from MEM/WB
//  wb         in   1   write-back select: 1=memRead, 0=ALUResult
//  regOp1     in   AW  primary destination register
//  memRead    in   DW  load data from MEM/WB
//  ALUResult  in   DW  ALU result from MEM/WB
//  swapEn     in   1   swap: op2Val->regOp1, op1Val->regOp2 (overrides wb select)
//  regOp2     in   AW  second destination, used only when swapEn=1
//  op1Val     in   DW  original operand-1 value
//  op2Val     in   DW  original operand-2 value
//  R15Wrt     in   1   write enable for R15Result into R15IDX
//  R15Result  in   DW  side result (mul/div high word or remainder)
//  rdAddr1    in   AW  read port 1 address
//  rdAddr2    in   AW  read port 2 address
//  rdData1    out  DW  read port 1 data (combinational)
//  rdData2    out  DW  read port 2 data (combinational)
//  r15Data    out  DW  current R15 value (combinational)
//  wbValid    out  1   registered: a primary write committed last cycle
//  wbAddr     out  AW  registered: address of that write
//  wbData     out  DW  registered: value of that write (forwarding source)
// BEHAVIOUR
//  - Reset (async, rst=1): all 16 registers=0, wbValid=0, wbAddr=0, wbData=0; so rdData1/2=0 and r15Data=0.
//    Writes while rst=1 are ignored. Deassertion takes effect at the next clock edge.
//  - Primary value P: swapEn ? op2Val : (wb ? memRead : ALUResult).
//  - Primary write: on posedge when RegWrt=1, reg[regOp1] <= P.
//  - Swap write: on posedge when RegWrt=1 and swapEn=1, also reg[regOp2] <= op1Val.
//    swapEn with RegWrt=0 writes nothing.
//  - R15 write: on posedge when R15Wrt=1, reg[R15IDX] <= R15Result.
//  - Register 0 reads as 0 on every port; writes to it are discarded (wbValid still reports them).
//  - Same-cycle collisions, priority high->low: R15Wrt, primary write, swap second write.
//    Example: regOp1=15 with RegWrt and R15Wrt both set -> R15 gets R15Result.
//    Example: swap with regOp1==regOp2 -> register gets op2Val.
//  - Read ports, write-through bypass: if rdAddrN matches a register being written this cycle (and !=0),
//    rdDataN returns the value that register will hold after the edge (collision priority applied).
//    Otherwise rdDataN returns the stored value. r15Data bypasses the same way.
//  - Latency: write visible on read ports in the same cycle (bypass) and stored from the next cycle.
//  - wbValid/wbAddr/wbData: registered copy of RegWrt, regOp1 and P each cycle; wbValid=0 when RegWrt=0.
//    wbAddr/wbData hold their previous values when wbValid=0.
//  - No X propagation: unused inputs (regOp2 when swapEn=0) do not affect state.
// TESTING
//  - Reset: rst=1 mid-run after writes -> all rdData=0, r15Data=0, wbValid=0 immediately (async).
//  - Load: RegWrt=1, wb=1, regOp1=3, memRead=16'hBEEF, rdAddr1=3 -> rdData1=BEEF same cycle and after edge; wbValid=1, wbAddr=3 next cycle.
//  - ALU: wb=0, ALUResult=16'h0012, regOp1=0 -> rdData1(addr0)=0 always; wbValid=1, wbData=0012.
//  - Swap: regOp1=4, regOp2=5, op1Val=1111, op2Val=2222, swapEn=1 -> R4=2222, R5=1111; regOp1=regOp2=6 -> R6=2222.
//  - Collision: RegWrt=1, regOp1=15, ALUResult=AAAA, R15Wrt=1, R15Result=5555 -> r15Data=5555 (bypass and stored).
//  - Bypass: rdAddr2=7 while writing R7=0042 -> rdData2=0042 before edge; prior R7 value never seen after edge.

Source files
------------

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: write-back controls, swap/R15 side writes and the ID-stage read ports.
interface wb_regfile_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    logic          RegWrt;
    logic          wb;
    logic [AW-1:0] regOp1;
    logic [DW-1:0] memRead;
    logic [DW-1:0] ALUResult;
    logic          swapEn;
    logic [AW-1:0] regOp2;
    logic [DW-1:0] op1Val;
    logic [DW-1:0] op2Val;
    logic          R15Wrt;
    logic [DW-1:0] R15Result;
    logic [AW-1:0] rdAddr1;
    logic [AW-1:0] rdAddr2;
    logic [DW-1:0] rdData1;
    logic [DW-1:0] rdData2;
    logic [DW-1:0] r15Data;
    logic          wbValid;
    logic [AW-1:0] wbAddr;
    logic [DW-1:0] wbData;

    modport master (
        output RegWrt, wb, regOp1, memRead, ALUResult, swapEn, regOp2, op1Val, op2Val,
               R15Wrt, R15Result, rdAddr1, rdAddr2,
        input  rdData1, rdData2, r15Data, wbValid, wbAddr, wbData
    );

    modport slave (
        input  RegWrt, wb, regOp1, memRead, ALUResult, swapEn, regOp2, op1Val, op2Val,
               R15Wrt, R15Result, rdAddr1, rdAddr2,
        output rdData1, rdData2, r15Data, wbValid, wbAddr, wbData
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage plus register file: commits primary, swap and R15 writes, with
// write-through bypass on both ID read ports and the R15 read port.
module wb_regfile #(
    parameter int DW     = 16,
    parameter int AW     = 4,
    parameter int R15IDX = 15
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);
    localparam int NREG = 2 ** AW;
    localparam logic [AW-1:0] R15_ADDR = AW'(R15IDX);

    logic [DW-1:0] regs   [NREG];
    logic [DW-1:0] wr_val [NREG];
    logic [NREG-1:0] wr_en;
    logic [DW-1:0] prim_val;

    assign prim_val = bus.swapEn ? bus.op2Val : (bus.wb ? bus.memRead : bus.ALUResult);

    // Per-register next-value resolution; later assignments win, giving R15 > primary > swap.
    // Register 0 is never enabled, so it stays zero and bypass never exposes a write to it.
    always_comb begin
        wr_en = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            wr_val[i] = '0;
        end
        if (!rst) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (bus.RegWrt && bus.swapEn && bus.regOp2 == AW'(i)) begin
                    wr_en[i]  = 1'b1;
                    wr_val[i] = bus.op1Val;
                end
                if (bus.RegWrt && bus.regOp1 == AW'(i)) begin
                    wr_en[i]  = 1'b1;
                    wr_val[i] = prim_val;
                end
                if (bus.R15Wrt && R15_ADDR == AW'(i)) begin
                    wr_en[i]  = 1'b1;
                    wr_val[i] = bus.R15Result;
                end
            end
        end
    end

    assign bus.rdData1 = wr_en[bus.rdAddr1] ? wr_val[bus.rdAddr1] : regs[bus.rdAddr1];
    assign bus.rdData2 = wr_en[bus.rdAddr2] ? wr_val[bus.rdAddr2] : regs[bus.rdAddr2];
    assign bus.r15Data = wr_en[R15_ADDR]    ? wr_val[R15_ADDR]    : regs[R15_ADDR];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= wr_val[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wbValid <= 1'b0;
            bus.wbAddr  <= '0;
            bus.wbData  <= '0;
        end else begin
            bus.wbValid <= bus.RegWrt;
            if (bus.RegWrt) begin
                bus.wbAddr <= bus.regOp1;
                bus.wbData <= prim_val;
            end
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed-vector bench for wb_regfile: bypass reads before the edge, write-back record after it.
module tb_wb_regfile;
    logic clk;
    logic rst;

    wb_regfile_if #(.DW(16), .AW(4)) bus ();

    wb_regfile #(.DW(16), .AW(4), .R15IDX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        regwrt;
        logic        wbsel;
        logic        swapen;
        logic        r15wrt;
        logic [3:0]  op1;
        logic [3:0]  op2;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [15:0] mem;
        logic [15:0] alu;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [15:0] r15res;
        logic [15:0] e_rd1;
        logic [15:0] e_rd2;
        logic [15:0] e_r15;
        logic        e_valid;
        logic [3:0]  e_addr;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs[12];
    int   passed;
    int   total;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic apply(input vec_t v);
        bus.RegWrt    = v.regwrt;
        bus.wb        = v.wbsel;
        bus.swapEn    = v.swapen;
        bus.R15Wrt    = v.r15wrt;
        bus.regOp1    = v.op1;
        bus.regOp2    = v.op2;
        bus.rdAddr1   = v.ra1;
        bus.rdAddr2   = v.ra2;
        bus.memRead   = v.mem;
        bus.ALUResult = v.alu;
        bus.op1Val    = v.v1;
        bus.op2Val    = v.v2;
        bus.R15Result = v.r15res;
    endtask

    task automatic idle();
        bus.RegWrt = 0; bus.wb = 0; bus.swapEn = 0; bus.R15Wrt = 0;
        bus.regOp1 = 0; bus.regOp2 = 0; bus.rdAddr1 = 0; bus.rdAddr2 = 0;
        bus.memRead = 0; bus.ALUResult = 0; bus.op1Val = 0; bus.op2Val = 0; bus.R15Result = 0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        //          name        rw wb sw 15 op1 op2 ra1 ra2 mem      alu      v1       v2       r15res   rd1      rd2      r15      vld a     data
        vecs[0]  = '{"load",     1, 1, 0, 0, 3,  0,  3,  0, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 1, 3,  16'hBEEF};
        vecs[1]  = '{"hold",     0, 0, 0, 0, 9,  0,  3,  3, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000, 0, 3,  16'hBEEF};
        vecs[2]  = '{"alu_r0",   1, 0, 0, 0, 0,  0,  0,  3, 16'h0000, 16'h0012, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 1, 0,  16'h0012};
        vecs[3]  = '{"swap",     1, 1, 1, 0, 4,  5,  4,  5, 16'h9999, 16'h8888, 16'h1111, 16'h2222, 16'h0000, 16'h2222, 16'h1111, 16'h0000, 1, 4,  16'h2222};
        vecs[4]  = '{"swap_eq",  1, 0, 1, 0, 6,  6,  6,  4, 16'h0000, 16'h0000, 16'h1111, 16'h2222, 16'h0000, 16'h2222, 16'h2222, 16'h0000, 1, 6,  16'h2222};
        vecs[5]  = '{"swap_nw",  0, 0, 1, 0, 7,  8,  7,  8, 16'h0000, 16'h0000, 16'h3333, 16'h4444, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 6,  16'h2222};
        vecs[6]  = '{"coll_r15", 1, 0, 0, 1, 15, 0, 15,  5, 16'h0000, 16'hAAAA, 16'h0000, 16'h0000, 16'h5555, 16'h5555, 16'h1111, 16'h5555, 1, 15, 16'hAAAA};
        vecs[7]  = '{"bypass",   1, 0, 0, 0, 7,  0, 15,  7, 16'h0000, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 16'h5555, 16'h0042, 16'h5555, 1, 7,  16'h0042};
        vecs[8]  = '{"r15_only", 0, 0, 0, 1, 0,  0,  7, 15, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h0042, 16'h1234, 16'h1234, 0, 7,  16'h0042};
        vecs[9]  = '{"swap_r15", 1, 0, 1, 1, 9, 15,  9, 15, 16'h0000, 16'h0000, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hBBBB, 16'hCCCC, 16'hCCCC, 1, 9,  16'hBBBB};
        vecs[10] = '{"readback", 0, 0, 0, 0, 0,  0, 15,  9, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hCCCC, 16'hBBBB, 16'hCCCC, 0, 9,  16'hBBBB};
        vecs[11] = '{"swap_r0",  1, 0, 1, 0, 10, 0,  0, 10, 16'h0000, 16'h0000, 16'h7777, 16'h6666, 16'h0000, 16'h0000, 16'h6666, 16'hCCCC, 1, 10, 16'h6666};

        idle();
        rst = 1'b1;
        #12;
        check("rst_rd1", bus.rdData1, 16'h0000);
        check("rst_r15", bus.r15Data, 16'h0000);
        check("rst_valid", {15'd0, bus.wbValid}, 16'h0000);
        check("rst_data", bus.wbData, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #2;
            check({vecs[i].name, "_rd1"}, bus.rdData1, vecs[i].e_rd1);
            check({vecs[i].name, "_rd2"}, bus.rdData2, vecs[i].e_rd2);
            check({vecs[i].name, "_r15"}, bus.r15Data, vecs[i].e_r15);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_valid"}, {15'd0, bus.wbValid}, {15'd0, vecs[i].e_valid});
            check({vecs[i].name, "_addr"}, {12'd0, bus.wbAddr}, {12'd0, vecs[i].e_addr});
            check({vecs[i].name, "_data"}, bus.wbData, vecs[i].e_data);
        end

        // Stored values with no write in flight.
        @(negedge clk);
        idle();
        bus.rdAddr1 = 4'd4;
        bus.rdAddr2 = 4'd7;
        #2;
        check("stored_r4", bus.rdData1, 16'h2222);
        check("stored_r7", bus.rdData2, 16'h0042);
        bus.rdAddr1 = 4'd6;
        bus.rdAddr2 = 4'd10;
        #1;
        check("stored_r6", bus.rdData1, 16'h2222);
        check("stored_r10", bus.rdData2, 16'h6666);
        bus.rdAddr1 = 4'd3;
        bus.rdAddr2 = 4'd5;
        #1;
        check("stored_r3", bus.rdData1, 16'hBEEF);
        check("stored_r5", bus.rdData2, 16'h1111);

        // Mid-cycle async reset with a write request pending on the bus.
        bus.RegWrt    = 1'b1;
        bus.regOp1    = 4'd3;
        bus.ALUResult = 16'h5A5A;
        bus.R15Wrt    = 1'b1;
        bus.R15Result = 16'h7E7E;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_rd1", bus.rdData1, 16'h0000);
        check("arst_rd2", bus.rdData2, 16'h0000);
        check("arst_r15", bus.r15Data, 16'h0000);
        check("arst_valid", {15'd0, bus.wbValid}, 16'h0000);
        check("arst_addr", {12'd0, bus.wbAddr}, 16'h0000);
        @(posedge clk);
        #1;
        check("rst_wr_ign", bus.rdData1, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        idle();
        bus.rdAddr1 = 4'd3;
        bus.rdAddr2 = 4'd15;
        #2;
        check("post_rst_r3", bus.rdData1, 16'h0000);
        check("post_rst_r15", bus.rdData2, 16'h0000);
        @(posedge clk);
        #1;
        check("post_rst_valid", {15'd0, bus.wbValid}, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
